conv_enc_k3: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric units.
- Accepts a serial frame of FRAME_LEN data bits over a valid/ready handshake.
- Emits one 2-bit code symbol per accepted bit, then K-1=2 zero tail symbols that return the trellis to state 00.
- Drives the symbol stream consumed by the channel model / decoder testbench.

---
 rtl/conv_enc_k3.sv | 158 +++++++++++++++
 tb/tb_conv_enc_k3.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_k3.sv
// conv_enc_k3 -- rate-1/2, constraint-length-3 convolutional encoder.
//
// Accepts a serial frame of FRAME_LEN data bits over a valid/ready handshake.
// Each accepted bit produces one 2-bit code symbol. After the frame, two zero
// tail symbols drive the trellis back to state 00. The second tail symbol is
// flagged with enc_last.
//
// Parameters:
//   FRAME_LEN  data bits per frame (1..65535)
//   G0         generator for enc_sym[1]; bit 2 taps the current input bit
//   G1         generator for enc_sym[0]
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   din_bit    data bit
//   din_valid  din_bit valid
//   din_ready  encoder can accept din_bit this cycle
//   enc_sym    code symbol {g0 parity, g1 parity}
//   enc_valid  enc_sym valid
//   enc_ready  downstream accepts enc_sym
//   enc_last   final (second tail) symbol of a frame
//   frame_cnt  completed-frame counter, present only with CONV_ENC_FRAME_CNT_EN
//
// Optional feature macro: CONV_ENC_FRAME_CNT_EN
//   When defined, adds frame_cnt[15:0]. It counts handshaked enc_last symbols
//   and wraps from 16'hFFFF to 0.
module conv_enc_k3 #(
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [2:0]  G0        = 3'b111,
    parameter logic [2:0]  G1        = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_bit,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [1:0]  enc_sym,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic        enc_last
`ifdef CONV_ENC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

    state_t      state, state_nxt;
    logic [1:0]  sr, sr_nxt;              // sr[1] = previous bit, sr[0] = the one before
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic        tail_cnt, tail_cnt_nxt;  // which of the two tail symbols is next
    logic        slot_free;
    logic        accept;
    logic        gen;                     // a symbol is loaded into the output register
    logic        u;                       // encoder input: din_bit, or 0 during the tail
    logic        last_nxt;
    logic [2:0]  v;
    logic [1:0]  sym_nxt;

    // The output register can take a new symbol if it is empty or being drained.
    assign slot_free = !enc_valid || enc_ready;
    assign din_ready = !rst && ((state == IDLE) || (state == DATA)) && slot_free;
    assign accept    = din_valid && din_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        bit_cnt_nxt  = bit_cnt;
        tail_cnt_nxt = tail_cnt;
        gen          = 1'b0;
        u            = 1'b0;
        last_nxt     = 1'b0;

        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    gen = 1'b1;
                    u   = din_bit;
                    // bit_cnt is 0 in IDLE, so FRAME_LEN==1 goes straight to TAIL.
                    if (bit_cnt + 16'd1 == FRAME_LEN_W) begin
                        state_nxt   = TAIL;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = bit_cnt + 16'd1;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    gen          = 1'b1;
                    tail_cnt_nxt = !tail_cnt;
                    if (tail_cnt) begin
                        // Two zeros have been shifted in, so sr is 00 on return to IDLE.
                        last_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        v       = {u, sr};
        sym_nxt = {^(v & G0), ^(v & G1)};
        if (gen) begin
            sr_nxt = {u, sr[1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            tail_cnt  <= 1'b0;
            enc_sym   <= '0;
            enc_valid <= 1'b0;
            enc_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tail_cnt <= tail_cnt_nxt;
            if (gen) begin
                enc_sym   <= sym_nxt;
                enc_valid <= 1'b1;
                enc_last  <= last_nxt;
            end else if (enc_ready) begin
                // enc_sym keeps its last value; only the qualifiers drop.
                enc_valid <= 1'b0;
                enc_last  <= 1'b0;
            end
        end
    end

`ifdef CONV_ENC_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (enc_valid && enc_ready && enc_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_enc_k3.sv
// Self-checking bench for conv_enc_k3.
// The main DUT uses FRAME_LEN=4. A second instance with FRAME_LEN=1 covers the
// single-bit-frame boundary. Expected symbols go into a scoreboard queue when
// bits are accepted. A negedge monitor pops the queue and compares on every
// enc_valid && enc_ready transfer.
module tb_conv_enc_k3;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_bit = 1'b0, din_valid = 1'b0, din_ready;
    logic [1:0] enc_sym;
    logic       enc_valid, enc_last;
    logic       enc_ready = 1'b1;
`ifdef CONV_ENC_FRAME_CNT_EN
    logic [15:0] frame_cnt, d1_frame_cnt;
`endif

    logic       d1_bit = 1'b0, d1_valid = 1'b0, d1_ready;
    logic [1:0] d1_sym;
    logic       d1_evalid, d1_last;
    logic       d1_eready = 1'b1;

    conv_enc_k3 #(.FRAME_LEN(FL), .G0(3'b111), .G1(3'b101)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din_bit   (din_bit),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .enc_sym   (enc_sym),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .enc_last  (enc_last)
`ifdef CONV_ENC_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    conv_enc_k3 #(.FRAME_LEN(1), .G0(3'b111), .G1(3'b101)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .din_bit   (d1_bit),
        .din_valid (d1_valid),
        .din_ready (d1_ready),
        .enc_sym   (d1_sym),
        .enc_valid (d1_evalid),
        .enc_ready (d1_eready),
        .enc_last  (d1_last)
`ifdef CONV_ENC_FRAME_CNT_EN
        ,
        .frame_cnt (d1_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    typedef struct {
        logic [3:0]  bits;   // first bit in bits[3]
        logic [11:0] syms;   // first symbol in syms[11:10]
    } vec_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         xfer_cyc[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [1:0] held;
    vec_t       vecs[4];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: outputs are stable at the negedge, and the transfer
    // happens at the following posedge.
    always @(negedge clk) begin
        if (!rst && enc_valid && enc_ready) begin
            xfer_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sym: got %b last %b with empty scoreboard", enc_sym, enc_last);
            end else begin
                mon_e = sb_q.pop_front();
                check("sym_last", {29'd0, enc_sym, enc_last}, {29'd0, mon_e.sym, mon_e.last});
            end
        end
    end

    function automatic logic [11:0] model(input logic [3:0] bits);
        logic [1:0]  s = 2'b00;
        logic        u;
        logic [2:0]  v;
        logic [11:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            u = (i < 4) ? bits[3-i] : 1'b0;
            v = {u, s};
            r[11-2*i -: 2] = {^(v & 3'b111), ^(v & 3'b101)};
            s = {u, s[1]};
        end
        return r;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic l);
        exp_t e;
        e.sym  = s;
        e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, output bit ok);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        din_bit   = b;
        din_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            n++;
        end
        ok = acc;
    endtask

    task automatic send_frame(input logic [3:0] bits, input logic [11:0] syms, input bit hold);
        bit ok;
        for (int i = 0; i < 4; i++) begin
            drive_bit(bits[3-i], ok);
            check("accept", {31'd0, ok}, 32'd1);
            push(syms[11-2*i -: 2], 1'b0);
        end
        push(syms[3:2], 1'b0);
        push(syms[1:0], 1'b1);
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            sync();
            n++;
        end
        check("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rb;
        bit         ok;

        vecs[0] = '{bits: 4'b1011, syms: 12'b11_10_00_01_01_11};
        vecs[1] = '{bits: 4'b0000, syms: 12'b00_00_00_00_00_00};
        vecs[2] = '{bits: 4'b1111, syms: 12'b11_01_10_10_01_11};
        vecs[3] = '{bits: 4'b0110, syms: 12'b00_11_01_01_11_00};

        // Reset state while rst is held high.
        #12;
        check("rst_valid",  {31'd0, enc_valid}, 32'd0);
        check("rst_sym",    {30'd0, enc_sym},   32'd0);
        check("rst_last",   {31'd0, enc_last},  32'd0);
        check("rst_ready",  {31'd0, din_ready}, 32'd0);
        check("rst_ready1", {31'd0, d1_ready},  32'd0);
        sync();
        rst = 1'b0;
        sync();

        // FRAME_LEN=1: one data symbol followed immediately by the two tail symbols.
        d1_bit   = 1'b1;
        d1_valid = 1'b1;
        @(negedge clk);
        check("d1_ready_idle", {31'd0, d1_ready}, 32'd1);
        sync();
        d1_valid = 1'b0;
        @(negedge clk);
        check("d1_sym0", {28'd0, d1_evalid, d1_sym, d1_last}, 32'b1110);
        check("d1_ready_t0", {31'd0, d1_ready}, 32'd0);
        @(negedge clk);
        check("d1_sym1", {28'd0, d1_evalid, d1_sym, d1_last}, 32'b1100);
        check("d1_ready_t1", {31'd0, d1_ready}, 32'd0);
        @(negedge clk);
        check("d1_sym2", {28'd0, d1_evalid, d1_sym, d1_last}, 32'b1111);
        check("d1_ready_back", {31'd0, d1_ready}, 32'd1);
        @(negedge clk);
        check("d1_idle_valid", {31'd0, d1_evalid}, 32'd0);

        // Table-driven frames with enc_ready high; din_ready drops for exactly 2 tail cycles.
        for (int k = 0; k < 4; k++) begin
            sync();
            check("model_vs_table", {20'd0, model(vecs[k].bits)}, {20'd0, vecs[k].syms});
            send_frame(vecs[k].bits, vecs[k].syms, 1'b0);
            @(negedge clk);
            check("tail_ready0", {31'd0, din_ready}, 32'd0);
            @(negedge clk);
            check("tail_ready1", {31'd0, din_ready}, 32'd0);
            @(negedge clk);
            check("tail_ready_back", {31'd0, din_ready}, 32'd1);
            drain();
        end

        // Random frames checked against the reference model.
        for (int k = 0; k < 4; k++) begin
            sync();
            rb = 4'($urandom_range(0, 15));
            send_frame(rb, model(rb), 1'b0);
            drain();
        end

        // Backpressure: stall 3 cycles after the second symbol.
        sync();
        fork
            send_frame(4'b1011, 12'b11_10_00_01_01_11, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 enc_ready = 1'b0;
                @(negedge clk);
                held = enc_sym;
                check("bp_held", {30'd0, held}, 32'b10);
                check("bp_valid", {31'd0, enc_valid}, 32'd1);
                check("bp_ready", {31'd0, din_ready}, 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("bp_sym", {30'd0, enc_sym}, {30'd0, held});
                    check("bp_valid", {31'd0, enc_valid}, 32'd1);
                    check("bp_ready", {31'd0, din_ready}, 32'd0);
                end
                @(posedge clk);
                #1 enc_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back frames with din_valid held high: 12 gapless transfers.
        sync();
        xfer_cyc.delete();
        send_frame(4'b1011, 12'b11_10_00_01_01_11, 1'b1);
        send_frame(4'b1111, 12'b11_01_10_10_01_11, 1'b0);
        drain();
        check("b2b_count", xfer_cyc.size(), 32'd12);
        if (xfer_cyc.size() == 12) begin
            check("b2b_span", xfer_cyc[11] - xfer_cyc[0], 32'd11);
        end

        // Reset mid-frame after two bits; the partial frame is discarded.
        sync();
        drive_bit(1'b1, ok);
        check("accept", {31'd0, ok}, 32'd1);
        push(2'b11, 1'b0);
        drive_bit(1'b0, ok);
        check("accept", {31'd0, ok}, 32'd1);
        push(2'b10, 1'b0);
        #3 rst = 1'b1;
        din_valid = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, enc_valid}, 32'd0);
        check("mid_rst_sym",   {30'd0, enc_sym},   32'd0);
        check("mid_rst_last",  {31'd0, enc_last},  32'd0);
        check("mid_rst_ready", {31'd0, din_ready}, 32'd0);
        sb_q.delete();
        sync();
        rst = 1'b0;
        sync();
        send_frame(4'b1011, 12'b11_10_00_01_01_11, 1'b0);
        drain();

`ifdef CONV_ENC_FRAME_CNT_EN
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        sync();
        check("fc_reset", {16'd0, frame_cnt}, 32'd0);
        repeat (3) begin
            send_frame(4'b1011, 12'b11_10_00_01_01_11, 1'b0);
            drain();
        end
        sync();
        check("fc_three", {16'd0, frame_cnt}, 32'd3);
        force u_dut.frame_cnt = 16'hFFFF;
        sync();
        release u_dut.frame_cnt;
        send_frame(4'b0000, 12'b00_00_00_00_00_00, 1'b0);
        drain();
        sync();
        check("fc_wrap", {16'd0, frame_cnt}, 32'd0);
`endif

        // Idle tail: the monitor flags any stray symbol.
        repeat (10) sync();
        check("final_sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
